// File: rtl/debug_probe_unit.sv
// rtl/debug_probe_unit.sv - host-command debug unit: pipeline single-step and probe capture streamed out as bytes
// Optional feature macro: DBG_STEP_COUNT_EN (32-bit step counter; selector 6'h3C captures it, 6'h3D clears it)
module debug_probe_unit #(
  parameter int         NUM_PROBES = 32,
  parameter int         PROBE_W    = 32,
  parameter logic [7:0] ACK_STEP   = 8'hFF,
  parameter logic [7:0] ACK_NOP    = 8'h55
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    code,
  input  logic                          code_valid,
  output logic                          code_ready,
  input  logic [NUM_PROBES*PROBE_W-1:0] probe_bus,
  output logic                          step_en,
  output logic [7:0]                    tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic                          busy
);

  localparam logic [5:0] SEL_STEP = 6'h3F;
  localparam logic [5:0] SEL_NOP  = 6'h38;

  typedef enum logic [1:0] {S_IDLE, S_STEP, S_CAPTURE, S_SEND} state_t;

  state_t      r_state;
  logic [7:0]  r_code;
  logic [31:0] r_snap;
  logic [1:0]  r_idx;
  logic        r_step_en;
  logic        r_tx_valid;
  logic [7:0]  r_tx_data;
  logic        r_busy;

  logic [31:0] w_probe;
  logic [31:0] w_capture;

`ifdef DBG_STEP_COUNT_EN
  localparam logic [5:0] SEL_CNT = 6'h3C;
  localparam logic [5:0] SEL_CLR = 6'h3D;

  logic [31:0] r_count;

  // Count every step pulse; a clear command zeroes the count in its capture cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (r_state == S_CAPTURE && r_code[5:0] == SEL_CLR) begin
      r_count <= '0;
    end else if (r_step_en) begin
      r_count <= r_count + 32'd1;
    end
  end
`endif

  // Select the addressed probe channel, zero-extended; out-of-range selectors yield 0
  always_comb begin
    w_probe = '0;
    for (int k = 0; k < NUM_PROBES; k++) begin
      if (32'(r_code[5:0]) == k) begin
        w_probe[PROBE_W-1:0] = probe_bus[k*PROBE_W +: PROBE_W];
      end
    end
  end

  // Snapshot source: ACK bytes and special selectors win over probe channels
  always_comb begin
    w_capture = '0;
    if (r_code[5:0] == SEL_STEP) begin
      w_capture = {24'b0, ACK_STEP};
    end else if (r_code[5:0] == SEL_NOP) begin
      w_capture = {24'b0, ACK_NOP};
`ifdef DBG_STEP_COUNT_EN
    end else if (r_code[5:0] == SEL_CNT) begin
      w_capture = r_count;
    end else if (r_code[5:0] == SEL_CLR) begin
      w_capture = {24'b0, ACK_NOP};
`endif
    end else begin
      w_capture = w_probe;
    end
  end

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] i);
    case (i)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  // Command FSM: accept, optionally step, snapshot, then serialize LSB first
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_code     <= '0;
      r_snap     <= '0;
      r_idx      <= '0;
      r_step_en  <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_step_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (code_valid && !r_busy) begin
            r_code <= code;
            r_busy <= 1'b1;
            if (code[5:0] == SEL_STEP) begin
              r_state   <= S_STEP;
              r_step_en <= 1'b1;
            end else begin
              r_state <= S_CAPTURE;
            end
          end
        end
        S_STEP: begin
          r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          r_snap     <= w_capture;
          r_tx_data  <= w_capture[7:0];
          r_tx_valid <= 1'b1;
          r_idx      <= 2'd0;
          r_state    <= S_SEND;
        end
        S_SEND: begin
          if (tx_ready) begin
            if (r_idx == r_code[7:6]) begin
              r_tx_valid <= 1'b0;
              r_busy     <= 1'b0;
              r_state    <= S_IDLE;
            end else begin
              r_idx     <= r_idx + 2'd1;
              r_tx_data <= byte_of(r_snap, r_idx + 2'd1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign code_ready = ~r_busy;
  assign busy       = r_busy;
  assign step_en    = r_step_en;
  assign tx_valid   = r_tx_valid;
  assign tx_data    = r_tx_data;

endmodule

// File: tb/tb_debug_probe_unit.sv
// tb/tb_debug_probe_unit.sv - table, corner-case and randomized checks of debug_probe_unit against a command-level model
module tb_debug_probe_unit;

`ifdef DBG_STEP_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic [7:0]        code;
  logic              code_valid;
  logic              tx_ready;
  logic [31:0]       big_ch [32];
  logic [31:0]       sml_ch [4];
  logic [32*32-1:0]  big_bus;
  logic [4*8-1:0]    sml_bus;

  logic              code_ready, step_en, tx_valid, busy;
  logic [7:0]        tx_data;
  logic              s_code_ready, s_step_en, s_tx_valid, s_busy;
  logic [7:0]        s_tx_data;

  int                n_vec;
  int                n_bad;
  int unsigned       cnt_m;

  typedef struct {
    logic [7:0]  code;
    int          n;
    int          lat;
    int          st;
    logic [31:0] bw;
    logic [31:0] sw;
  } vec_t;

  vec_t tbl [11];

  debug_probe_unit u_big (
    .clk        (clk),
    .reset      (reset),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .probe_bus  (big_bus),
    .step_en    (step_en),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy)
  );

  debug_probe_unit #(.NUM_PROBES(4), .PROBE_W(8)) u_small (
    .clk        (clk),
    .reset      (reset),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (s_code_ready),
    .probe_bus  (sml_bus),
    .step_en    (s_step_en),
    .tx_data    (s_tx_data),
    .tx_valid   (s_tx_valid),
    .tx_ready   (tx_ready),
    .busy       (s_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    for (int k = 0; k < 32; k++) big_bus[k*32 +: 32] = big_ch[k];
    for (int k = 0; k < 4; k++)  sml_bus[k*8 +: 8]   = sml_ch[k][7:0];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Snapshot a command should produce, from the command rules alone
  function automatic logic [31:0] exp_snap(input logic [7:0] c, input int np, input int pw,
                                           input logic [31:0] chv, input int unsigned cnt);
    int sel;
    sel = int'(c[5:0]);
    if (sel == 63) return 32'h0000_00FF;
    if (sel == 56) return 32'h0000_0055;
    if (CNT_EN && sel == 60) return cnt;
    if (CNT_EN && sel == 61) return 32'h0000_0055;
    if (sel < np) return (pw >= 32) ? chv : (chv & ((32'd1 << pw) - 32'd1));
    return 32'h0;
  endfunction

  function automatic logic [31:0] byte_mask(input int n);
    return (n >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
  endfunction

  function automatic void model_update(input logic [7:0] c);
    if (c[5:0] == 6'h3F) cnt_m = cnt_m + 1;
    if (CNT_EN && c[5:0] == 6'h3D) cnt_m = 0;
  endfunction

  // Issue one command from a negedge and collect everything both units send back
  // mode: 0 ready always high, 1 random ready, 2 alternating ready
  task automatic run_cmd(input logic [7:0] c, input int mode, input bit hold, input bit scramble,
                         output logic [31:0] bw, output logic [31:0] sw, output int nb, output int ns,
                         output int lat, output int bst, output int sst);
    bit         done;
    bit         hold_prev;
    logic [7:0] d_prev;
    bw = '0; sw = '0; nb = 0; ns = 0; lat = -1; bst = 0; sst = 0;
    done = 1'b0; hold_prev = 1'b0; d_prev = '0;
    code = c; code_valid = 1'b1; tx_ready = 1'b1;
    chk("code_ready_idle", 32'(code_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (hold) code = ~c;
    else code_valid = 1'b0;
    for (int cyc = 1; cyc < 300 && !done; cyc++) begin
      if (!busy) begin
        done = 1'b1;
      end else begin
        chk("code_ready_busy", 32'(code_ready), 32'd0);
        chk("small_busy", 32'(s_busy), 32'd1);
        if (step_en) bst++;
        if (s_step_en) sst++;
        if (tx_valid && lat < 0) lat = cyc;
        if (hold_prev) begin
          chk("stall_valid", 32'(tx_valid), 32'd1);
          chk("stall_data", 32'(tx_data), 32'(d_prev));
        end
        if (scramble && lat >= 0) begin
          for (int k = 0; k < 32; k++) big_ch[k] = $urandom;
          for (int k = 0; k < 4; k++)  sml_ch[k] = $urandom;
        end
        case (mode)
          0:       tx_ready = 1'b1;
          1:       tx_ready = ($urandom_range(0, 2) != 0);
          default: tx_ready = cyc[0];
        endcase
        if (tx_valid && tx_ready) begin
          if (nb < 4) bw[8*nb +: 8] = tx_data;
          nb++;
        end
        if (s_tx_valid && tx_ready) begin
          if (ns < 4) sw[8*ns +: 8] = s_tx_data;
          ns++;
        end
        hold_prev = tx_valid && !tx_ready;
        d_prev = tx_data;
        @(negedge clk);
      end
    end
    code_valid = 1'b0;
    tx_ready = 1'b1;
    if (!done) chk("cmd_timeout", 32'd0, 32'd1);
  endtask

  logic [31:0] bw, sw, eb, es;
  int          nb, ns, lat, bst, sst, nexp, sel;
  logic [5:0]  sp [5];

  initial begin
    n_vec = 0; n_bad = 0; cnt_m = 0;
    reset = 1'b1; code = '0; code_valid = 1'b0; tx_ready = 1'b0;
    for (int k = 0; k < 32; k++) big_ch[k] = '0;
    for (int k = 0; k < 4; k++)  sml_ch[k] = '0;
    big_ch[2] = 32'h0000_00C3; big_ch[3] = 32'h1234_5678;
    big_ch[5] = 32'hDEAD_BEEF; big_ch[7] = 32'h0000_0011;
    sml_ch[2] = 32'h7777_77A5; sml_ch[3] = 32'h0000_003C;
    sp[0] = 6'h3F; sp[1] = 6'h38; sp[2] = 6'h3C; sp[3] = 6'h3D; sp[4] = 6'h03;

    tbl[0]  = '{code: 8'hC5, n: 4, lat: 2, st: 0, bw: 32'hDEADBEEF, sw: 32'h0};
    tbl[1]  = '{code: 8'h3F, n: 1, lat: 3, st: 1, bw: 32'hFF, sw: 32'hFF};
    tbl[2]  = '{code: 8'h38, n: 1, lat: 2, st: 0, bw: 32'h55, sw: 32'h55};
    tbl[3]  = '{code: 8'h43, n: 2, lat: 2, st: 0, bw: 32'h5678, sw: 32'h3C};
    tbl[4]  = '{code: 8'hC2, n: 4, lat: 2, st: 0, bw: 32'hC3, sw: 32'hA5};
    tbl[5]  = '{code: 8'h07, n: 1, lat: 2, st: 0, bw: 32'h11, sw: 32'h0};
    tbl[6]  = '{code: 8'h7F, n: 2, lat: 3, st: 1, bw: 32'hFF, sw: 32'hFF};
    tbl[7]  = '{code: 8'h60, n: 2, lat: 2, st: 0, bw: 32'h0, sw: 32'h0};
    tbl[8]  = '{code: 8'hBC, n: 3, lat: 2, st: 0, bw: CNT_EN ? 32'h2 : 32'h0, sw: CNT_EN ? 32'h2 : 32'h0};
    tbl[9]  = '{code: 8'h7D, n: 2, lat: 2, st: 0, bw: CNT_EN ? 32'h55 : 32'h0, sw: CNT_EN ? 32'h55 : 32'h0};
    tbl[10] = '{code: 8'hBC, n: 3, lat: 2, st: 0, bw: 32'h0, sw: 32'h0};

    repeat (2) @(negedge clk);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_step_en", 32'(step_en), 32'd0);
    chk("rst_code_ready", 32'(code_ready), 32'd1);
    chk("rst_small_tx_valid", 32'(s_tx_valid), 32'd0);
    chk("rst_small_code_ready", 32'(s_code_ready), 32'd1);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      run_cmd(tbl[i].code, 0, 1'b0, 1'b0, bw, sw, nb, ns, lat, bst, sst);
      model_update(tbl[i].code);
      chk($sformatf("tbl%0d_count", i), nb, tbl[i].n);
      chk($sformatf("tbl%0d_small_count", i), ns, tbl[i].n);
      chk($sformatf("tbl%0d_bytes", i), bw, tbl[i].bw);
      chk($sformatf("tbl%0d_small_bytes", i), sw, tbl[i].sw);
      chk($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
      chk($sformatf("tbl%0d_steps", i), bst, tbl[i].st);
      chk($sformatf("tbl%0d_small_steps", i), sst, tbl[i].st);
    end

    // Stalled send with probe churn and a code held on the link while busy
    big_ch[3] = 32'h1234_5678;
    run_cmd(8'h43, 2, 1'b1, 1'b1, bw, sw, nb, ns, lat, bst, sst);
    chk("stall_bytes", bw, 32'h5678);
    chk("stall_count", nb, 2);
    @(negedge clk);
    chk("busy_code_not_queued", 32'(busy), 32'd0);
    chk("busy_code_no_tx", 32'(tx_valid), 32'd0);

    // Reset while the second byte of a four-byte send is on the link
    code = 8'hC5; code_valid = 1'b1; tx_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    code_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_send_valid", 32'(tx_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_step_en", 32'(step_en), 32'd0);
    chk("async_rst_small_tx_valid", 32'(s_tx_valid), 32'd0);
    #1 reset = 1'b0;
    cnt_m = 0;
    @(negedge clk);
    chk("post_rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("post_rst_code_ready", 32'(code_ready), 32'd1);

    // Randomized commands against the model
    for (int i = 0; i < 60; i++) begin
      logic [7:0] c;
      for (int k = 0; k < 32; k++) big_ch[k] = $urandom;
      for (int k = 0; k < 4; k++)  sml_ch[k] = $urandom;
      c = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 2) == 0) c[5:0] = sp[$urandom_range(0, 4)];
      sel  = int'(c[5:0]);
      nexp = int'(c[7:6]) + 1;
      eb = exp_snap(c, 32, 32, (sel < 32) ? big_ch[sel % 32] : 32'h0, cnt_m) & byte_mask(nexp);
      es = exp_snap(c, 4, 8, (sel < 4) ? sml_ch[sel % 4] : 32'h0, cnt_m) & byte_mask(nexp);
      run_cmd(c, 1, 1'($urandom_range(0, 1)), 1'b1, bw, sw, nb, ns, lat, bst, sst);
      model_update(c);
      chk($sformatf("rnd%0d_code%0h_bytes", i, c), bw, eb);
      chk($sformatf("rnd%0d_code%0h_small_bytes", i, c), sw, es);
      chk($sformatf("rnd%0d_code%0h_count", i, c), nb, nexp);
      chk($sformatf("rnd%0d_code%0h_latency", i, c), lat, (sel == 63) ? 3 : 2);
      chk($sformatf("rnd%0d_code%0h_steps", i, c), bst, (sel == 63) ? 1 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
